// File: rtl/round_timer_ctrl.sv
// Round sequencer for the Fruit Ninja datapath: ready countdown, timed play
// phase with pause, periodic spawn requests and the BCD seconds display.
module round_timer_ctrl #(
   parameter int ROUND_SECS     = 60,
   parameter int COUNTDOWN_SECS = 3,
   parameter int SPAWN_PERIOD   = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tick_1s,
   input  logic       start,
   input  logic       pause,
   input  logic       game_over_req,
   output logic [2:0] state,
   output logic [3:0] ready_cnt,
   output logic [3:0] secs_tens,
   output logic [3:0] secs_ones,
   output logic       play_en,
   output logic       spawn_pulse,
   output logic       time_up
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READY = 3'd1,
      PLAY  = 3'd2,
      PAUSE = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [3:0] ROUND_TENS = 4'(ROUND_SECS / 10);
   localparam logic [3:0] ROUND_ONES = 4'(ROUND_SECS % 10);
   localparam logic [3:0] READY_INIT = 4'(COUNTDOWN_SECS);
   localparam logic [3:0] SPAWN_LAST = 4'(SPAWN_PERIOD - 1);

   state_t     state_q, state_n;
   logic [3:0] ready_n, tens_n, ones_n;
   logic [3:0] spawn_cnt_q, spawn_cnt_n;
   logic       spawn_n, time_up_n;

   assign state = state_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         ready_cnt   <= READY_INIT;
         secs_tens   <= ROUND_TENS;
         secs_ones   <= ROUND_ONES;
         spawn_cnt_q <= 4'd0;
         play_en     <= 1'b0;
         spawn_pulse <= 1'b0;
         time_up     <= 1'b0;
      end else begin
         state_q     <= state_n;
         ready_cnt   <= ready_n;
         secs_tens   <= tens_n;
         secs_ones   <= ones_n;
         spawn_cnt_q <= spawn_cnt_n;
         play_en     <= (state_n == PLAY);
         spawn_pulse <= spawn_n;
         time_up     <= time_up_n;
      end
   end

   // In PLAY a game-over request beats pause, which beats the tick; a losing
   // tick neither decrements the time nor advances the spawn counter.
   always_comb begin
      state_n     = state_q;
      ready_n     = ready_cnt;
      tens_n      = secs_tens;
      ones_n      = secs_ones;
      spawn_cnt_n = spawn_cnt_q;
      spawn_n     = 1'b0;
      time_up_n   = 1'b0;
      case (state_q)
         IDLE, OVER: begin
            if (start) begin
               tens_n      = ROUND_TENS;
               ones_n      = ROUND_ONES;
               ready_n     = READY_INIT;
               spawn_cnt_n = 4'd0;
               state_n     = (COUNTDOWN_SECS == 0) ? PLAY : READY;
            end
         end
         READY: begin
            if (game_over_req) begin
               state_n = OVER;
            end else if (tick_1s) begin
               if (ready_cnt <= 4'd1) begin
                  ready_n     = 4'd0;
                  spawn_cnt_n = 4'd0;
                  state_n     = PLAY;
               end else begin
                  ready_n = ready_cnt - 4'd1;
               end
            end
         end
         PLAY: begin
            if (game_over_req) begin
               state_n = OVER;
            end else if (pause) begin
               state_n = PAUSE;
            end else if (tick_1s) begin
               if (spawn_cnt_q == SPAWN_LAST) begin
                  spawn_cnt_n = 4'd0;
                  spawn_n     = 1'b1;
               end else begin
                  spawn_cnt_n = spawn_cnt_q + 4'd1;
               end
               // The 00 case is unreachable here but is held rather than wrapped.
               if (secs_tens == 4'd0 && secs_ones == 4'd1) begin
                  ones_n    = 4'd0;
                  state_n   = OVER;
                  time_up_n = 1'b1;
               end else if (secs_ones == 4'd0) begin
                  if (secs_tens != 4'd0) begin
                     ones_n = 4'd9;
                     tens_n = secs_tens - 4'd1;
                  end
               end else begin
                  ones_n = secs_ones - 4'd1;
               end
            end
         end
         PAUSE: begin
            if (game_over_req) begin
               state_n = OVER;
            end else if (pause) begin
               state_n = PLAY;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Self-checking bench for round_timer_ctrl: an integer-seconds model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_round_timer_ctrl;

   localparam int ROUND = 12;
   localparam int CD    = 3;
   localparam int SP    = 2;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       tick_1s = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       game_over_req = 1'b0;
   logic [2:0] state;
   logic [3:0] ready_cnt, secs_tens, secs_ones;
   logic       play_en, spawn_pulse, time_up;

   int errors = 0;
   int checks = 0;
   int spawn_seen = 0;
   bit chk_en = 1'b0;

   int m_state = 0;
   int m_ready = CD;
   int m_time  = ROUND;
   int m_spawn = 0;
   bit m_spawn_p = 1'b0;
   bit m_time_up = 1'b0;

   round_timer_ctrl #(
      .ROUND_SECS(ROUND),
      .COUNTDOWN_SECS(CD),
      .SPAWN_PERIOD(SP)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .tick_1s(tick_1s),
      .start(start),
      .pause(pause),
      .game_over_req(game_over_req),
      .state(state),
      .ready_cnt(ready_cnt),
      .secs_tens(secs_tens),
      .secs_ones(secs_ones),
      .play_en(play_en),
      .spawn_pulse(spawn_pulse),
      .time_up(time_up)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         if (errors <= 40)
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Round model in whole seconds: time is a plain integer, digits derived from it.
   always @(posedge clk) begin
      m_spawn_p = 1'b0;
      m_time_up = 1'b0;
      if (!rstn) begin
         m_state = 0; m_ready = CD; m_time = ROUND; m_spawn = 0;
      end else if (m_state == 0 || m_state == 4) begin
         if (start) begin
            m_time = ROUND; m_ready = CD; m_spawn = 0;
            m_state = (CD == 0) ? 2 : 1;
         end
      end else if (m_state == 1) begin
         if (game_over_req) m_state = 4;
         else if (tick_1s) begin
            m_ready = m_ready - 1;
            if (m_ready == 0) begin m_state = 2; m_spawn = 0; end
         end
      end else if (m_state == 2) begin
         if (game_over_req) m_state = 4;
         else if (pause) m_state = 3;
         else if (tick_1s) begin
            m_spawn = m_spawn + 1;
            if (m_spawn == SP) begin m_spawn = 0; m_spawn_p = 1'b1; end
            m_time = m_time - 1;
            if (m_time == 0) begin m_state = 4; m_time_up = 1'b1; end
         end
      end else if (m_state == 3) begin
         if (game_over_req) m_state = 4;
         else if (pause) m_state = 2;
      end
   end

   always @(posedge clk) begin
      if (chk_en) begin
         #1;
         checkOutput("state", int'(state), m_state);
         checkOutput("ready_cnt", int'(ready_cnt), m_ready);
         checkOutput("secs_tens", int'(secs_tens), m_time / 10);
         checkOutput("secs_ones", int'(secs_ones), m_time % 10);
         checkOutput("play_en", int'(play_en), int'(m_state == 2));
         checkOutput("spawn_pulse", int'(spawn_pulse), int'(m_spawn_p));
         checkOutput("time_up", int'(time_up), int'(m_time_up));
         if (spawn_pulse) spawn_seen++;
      end
   end

   // Drive one cycle of inputs starting at a falling edge; returns at the next
   // falling edge with the resulting outputs visible.
   task automatic applyStimulus(input bit s, input bit p, input bit g, input bit t);
      @(negedge clk);
      start = s; pause = p; game_over_req = g; tick_1s = t;
      @(negedge clk);
      start = 1'b0; pause = 1'b0; game_over_req = 1'b0; tick_1s = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tickSec(input int n);
      repeat (n) begin
         idleCycles(9);
         applyStimulus(0, 0, 0, 1);
      end
   endtask

   task automatic checkDigits(input string name, input int tens, input int ones);
      checkOutput({name, "_tens"}, int'(secs_tens), tens);
      checkOutput({name, "_ones"}, int'(secs_ones), ones);
   endtask

   initial begin
      idleCycles(3);
      rstn = 1'b1;
      chk_en = 1'b1;
      checkOutput("reset_state", int'(state), 0);
      checkOutput("reset_ready", int'(ready_cnt), 3);
      checkDigits("reset", 1, 2);
      checkOutput("reset_play_en", int'(play_en), 0);

      // Start and ready countdown
      applyStimulus(1, 0, 0, 0);
      checkOutput("start_state", int'(state), 1);
      checkOutput("start_ready", int'(ready_cnt), 3);
      tickSec(1);
      checkOutput("ready_after1", int'(ready_cnt), 2);
      applyStimulus(1, 1, 0, 0);
      checkOutput("ready_ignores", int'(ready_cnt), 2);
      checkOutput("ready_ignores_state", int'(state), 1);
      tickSec(2);
      checkOutput("play_state", int'(state), 2);
      checkOutput("play_en_on", int'(play_en), 1);
      checkDigits("play_start", 1, 2);

      // Full round
      spawn_seen = 0;
      for (int i = 1; i <= ROUND; i++) begin
         tickSec(1);
         checkOutput("round_spawn", int'(spawn_pulse), int'(i % 2 == 0));
         if (i == 2) checkDigits("round_10", 1, 0);
         if (i == 3) checkDigits("round_borrow", 0, 9);
      end
      checkOutput("round_time_up", int'(time_up), 1);
      checkOutput("round_over", int'(state), 4);
      checkDigits("round_end", 0, 0);
      idleCycles(1);
      checkOutput("time_up_single", int'(time_up), 0);
      checkOutput("round_spawn_count", spawn_seen, 6);
      tickSec(1);
      checkDigits("over_hold", 0, 0);

      // Restart from OVER
      applyStimulus(1, 0, 0, 0);
      checkOutput("restart_state", int'(state), 1);
      checkOutput("restart_ready", int'(ready_cnt), 3);
      checkDigits("restart", 1, 2);
      tickSec(3);
      tickSec(1);
      checkOutput("restart_no_spawn1", int'(spawn_pulse), 0);
      tickSec(1);
      checkOutput("restart_spawn2", int'(spawn_pulse), 1);
      checkDigits("restart_t2", 1, 0);

      // Pause after 5 play ticks
      tickSec(3);
      checkDigits("pre_pause", 0, 7);
      applyStimulus(0, 1, 0, 0);
      checkOutput("paused_state", int'(state), 3);
      checkOutput("paused_play_en", int'(play_en), 0);
      for (int i = 0; i < 4; i++) begin
         tickSec(1);
         checkOutput("paused_no_spawn", int'(spawn_pulse), 0);
      end
      checkDigits("paused_hold", 0, 7);
      applyStimulus(0, 1, 0, 0);
      checkOutput("resume_state", int'(state), 2);
      tickSec(1);
      checkDigits("resume_tick", 0, 6);
      checkOutput("resume_spawn", int'(spawn_pulse), 1);

      // Simultaneous events
      idleCycles(9);
      applyStimulus(0, 1, 0, 1);
      checkOutput("pause_tick_state", int'(state), 3);
      checkDigits("pause_tick", 0, 6);
      applyStimulus(0, 1, 0, 0);
      tickSec(5);
      checkDigits("at_01", 0, 1);
      idleCycles(9);
      applyStimulus(0, 0, 1, 1);
      checkOutput("gor_tick_state", int'(state), 4);
      checkDigits("gor_tick", 0, 1);
      checkOutput("gor_no_time_up", int'(time_up), 0);

      // Reset mid-PLAY, with start ignored and back-to-back pause beforehand
      applyStimulus(1, 0, 0, 0);
      tickSec(3);
      tickSec(5);
      applyStimulus(1, 0, 0, 0);
      checkOutput("play_ignores_start", int'(state), 2);
      checkDigits("play_ignores_start", 0, 7);
      applyStimulus(0, 1, 0, 0);
      checkOutput("dbl_pause1", int'(state), 3);
      applyStimulus(0, 1, 0, 0);
      checkOutput("dbl_pause2", int'(state), 2);
      idleCycles(8);
      @(negedge clk);
      rstn = 1'b0;
      tick_1s = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      tick_1s = 1'b0;
      checkOutput("midreset_state", int'(state), 0);
      checkDigits("midreset", 1, 2);
      checkOutput("midreset_spawn", int'(spawn_pulse), 0);
      checkOutput("midreset_time_up", int'(time_up), 0);
      checkOutput("midreset_play_en", int'(play_en), 0);
      tickSec(1);
      checkOutput("idle_ignores_tick", int'(state), 0);

      idleCycles(2);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/round_timer_ctrl.md
# round_timer_ctrl

Sequences one game round for the Fruit Ninja datapath. It consumes the 1 Hz single-cycle tick from the seconds divider and runs a ready countdown, then a timed play phase with pause support. During play it issues periodic fruit-spawn requests. It drives the BCD seconds display and gates the rest of the game logic through `play_en`.

## Interface

Parameters:
- `ROUND_SECS`, 60: play-phase length in seconds; legal range 1..99.
- `COUNTDOWN_SECS`, 3: ready-phase length in seconds; legal range 0..15.
- `SPAWN_PERIOD`, 2: seconds between spawn pulses; legal range 1..15.

Ports:
- `clk`  in  1: system clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `tick_1s`  in  1: one-cycle pulse, once per second.
- `start`  in  1: one-cycle pulse, debounced upstream.
- `pause`  in  1: one-cycle pulse; toggles between PLAY and PAUSE.
- `game_over_req`  in  1: one-cycle pulse (bomb sliced or lives exhausted).
- `state`  out  3: IDLE=0, READY=1, PLAY=2, PAUSE=3, OVER=4.
- `ready_cnt`  out  4: remaining ready seconds.
- `secs_tens`  out  4: BCD tens digit of remaining play time.
- `secs_ones`  out  4: BCD ones digit of remaining play time.
- `play_en`  out  1: high exactly while `state`==PLAY.
- `spawn_pulse`  out  1: one-cycle spawn request.
- `time_up`  out  1: one-cycle pulse when the timer expires.

## Operation

- All outputs are registered.
- Reset values:
  - `state`=IDLE, `ready_cnt`=COUNTDOWN_SECS.
  - `secs_tens`/`secs_ones` = BCD(ROUND_SECS).
  - `play_en`, `spawn_pulse`, `time_up` = 0.
  - Internal `spawn_cnt` = 0.
- IDLE:
  - `start` reloads the time to ROUND_SECS and `ready_cnt` to COUNTDOWN_SECS.
  - Then goes to READY, or straight to PLAY if COUNTDOWN_SECS==0.
  - Ticks are ignored.
- READY:
  - Each tick decrements `ready_cnt`.
  - A tick with `ready_cnt`==1 sets it to 0 and enters PLAY.
  - `pause` and `start` are ignored.
  - `game_over_req` enters OVER.
- Entering PLAY clears `spawn_cnt`. The first spawn therefore comes SPAWN_PERIOD ticks into play.
- PLAY, on each tick:
  - BCD decrement. Ones 0 becomes 9 with tens decremented; otherwise ones decrements.
  - `spawn_cnt` increments. On the tick where `spawn_cnt`==SPAWN_PERIOD-1, `spawn_cnt` becomes 0 and `spawn_pulse` fires.
  - A tick with time==01 sets time to 00, enters OVER and fires `time_up`.
  - On the expiring tick, `spawn_pulse` still fires if the period completes on that same tick.
- PAUSE:
  - Ticks are ignored; time and `spawn_cnt` are frozen.
  - `pause` returns to PLAY. The tick phase is not resynchronised, so the first tick after resume counts as a full second.
  - `game_over_req` enters OVER.
- OVER:
  - Time is held: 00 if the timer expired, otherwise the value at the request.
  - `start` behaves as in IDLE (reload and go to READY/PLAY).
  - `pause` and ticks are ignored.
- `start` in READY, PLAY or PAUSE is ignored.
- Same-cycle priority in PLAY: `game_over_req` > `pause` > `tick_1s`.
  - A losing tick is dropped entirely: no decrement and no spawn.
  - OVER entered via `game_over_req` never asserts `time_up`.
- Reset mid-round overrides everything and takes effect on the next edge. No pulse is emitted in the reset cycle.
- Width rules: `spawn_cnt` is 4 bits. The BCD digits never leave 0..9. The time never decrements below 00.

## Timing

- Input pulse sampled at edge N: `state`, digits and `play_en` update at edge N (visible in cycle N+1).
- `spawn_pulse` and `time_up` are high for exactly the one cycle after the causing tick edge.
- No combinational path from any input to any output.
- Consecutive-cycle pulses on `pause` toggle twice (PLAY→PAUSE→PLAY).

## Test plan

Parameters for every scenario: ROUND_SECS=12, COUNTDOWN_SECS=3, SPAWN_PERIOD=2; ticks every 10 clk.

1. Reset then `start`:
   - `state` goes to READY with `ready_cnt`=3.
   - After 3 ticks: PLAY, `play_en`=1, digits 1/2.
2. Full round:
   - Digits step 12→11→10→09…→00; the 10→09 tens borrow is checked.
   - `spawn_pulse` fires on ticks 2, 4, …, 12 (6 pulses total).
   - `time_up` is a single cycle on the 12th tick; `state`=OVER, digits 0/0.
3. Pause:
   - `pause` after 5 play ticks, then 4 ticks while paused: digits hold at 07, no spawns.
   - `pause` again resumes; the next tick gives 06.
4. Simultaneous events:
   - `pause` and `tick_1s` in the same cycle: PAUSE entered, digits unchanged.
   - `game_over_req` and `tick_1s` with time=01: OVER, digits 01, `time_up`=0.
5. Restart from OVER:
   - `start` reloads to 12, `ready_cnt`=3, `spawn_cnt` cleared.
   - The first spawn comes on play tick 2.
6. Reset mid-PLAY:
   - `rstn`=0 for 1 cycle at time 07: IDLE, digits 12, all pulses 0.
   - `start` during PLAY ignored.
